mul_seq_32: RTL and testbench
=============================

MUL_SEQ_32 -- requirements
Module: mul_seq_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, the operand width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-005 SHALL have port op, input, 2 bits: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (RV32M encoding).
REQ-006 SHALL have ports a and b, input, 32 bits each: rs1 and rs2 operands.
REQ-007 SHALL have port flush, input, 1 bit: abort any operation in progress.
REQ-008 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-009 SHALL have port done, output, 1 bit: single-cycle pulse marking result valid.
REQ-010 SHALL have port result, output, 32 bits: low product word for MUL; high word otherwise.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, NEG_LO, NEG_HI, DONE.
REQ-012 SHALL accept start only in IDLE; start in any other state is ignored.
REQ-013 On acceptance, SHALL latch op and operand magnitudes: a is signed for MULH/MULHSU; b is signed for MULH only.
REQ-014 On acceptance, SHALL record neg = sign(a) XOR sign(b), counting only the operands treated as signed.
REQ-015 SHALL spend exactly 32 cycles in CALC, with a 6-bit counter counting 0..31.
REQ-016 Each CALC cycle: if the multiplier LSB is 1, hi = hi + mcand with 33-bit carry kept; then {carry,hi,lo} shifts right by one.
REQ-017 After CALC, SHALL go to NEG_LO if neg=1, else to DONE.
REQ-018 NEG_LO SHALL form lo = ~lo + 1, keeping the carry.
REQ-019 NEG_HI SHALL form hi = ~hi + carry.
REQ-020 NEG_HI SHALL be followed by DONE.
REQ-021 DONE SHALL assert done for one cycle, then return to IDLE.
REQ-022 Latency SHALL be done high 33 clocks after the accepting edge, or 35 clocks when neg=1.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 result SHALL update at entry to DONE and hold until the next DONE.
REQ-025 flush SHALL force IDLE on the next edge from any state, with no done pulse; result is unchanged.
REQ-026 flush takes priority over a simultaneous start, which is dropped.
REQ-027 start in the same cycle that done is high is ignored; the requester re-asserts start in IDLE.
REQ-028 All additions SHALL use one shared 32-bit adder, muxed by state; no other adders are allowed.

Reset
REQ-029 When rst_n=0 at an edge, SHALL enter IDLE with busy=0, done=0, result=0, and all internal registers 0.
REQ-030 Reset mid-operation SHALL abandon the operation without a done pulse; reset overrides flush and start.

Configuration
REQ-031 Macro MUL_SEQ_ZERO_BYPASS_EN, when defined: if either latched magnitude is 0, go IDLE->DONE directly, with result=0 and done high 1 clock after acceptance.
REQ-032 Without MUL_SEQ_ZERO_BYPASS_EN, zero operands SHALL take the full 33-clock path with result=0.

Structure
REQ-033 The shared package SHALL hold the op encodings (MUL_OP_MUL, MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU), the FSM state typedef, and CALC_CYCLES=32.
REQ-034 The datapath adder SHALL be a separate sub-module, add_c_32: 32-bit a/b/cin in, sum and cout out.
REQ-035 The FSM and registers SHALL reside in mul_seq_32.

Verification
REQ-036 MUL a=7, b=6 -> result 0x0000002A; done exactly 33 clocks after start.
REQ-037 MULHU a=b=0xFFFFFFFF -> result 0xFFFFFFFE. Repeat with MUL -> result 0x00000001; 33 clocks each.
REQ-038 MULH a=b=0x80000000 -> result 0x40000000 with no negation (33 clocks). MULHSU a=0xFFFFFFFF, b=2 -> result 0xFFFFFFFF; 35 clocks.
REQ-039 Start MUL 5*5, assert flush at clock 10 -> busy=0 next cycle, no done, previous result retained; a new start then completes normally.
REQ-040 Assert start while busy, and start together with flush -> both ignored; assert rst_n=0 during CALC -> all outputs 0 next cycle.
REQ-041 MUL a=0, b=123: with MUL_SEQ_ZERO_BYPASS_EN -> result 0 and done 1 clock after start; without it -> result 0 at 33 clocks.

Source files
------------

// File: rtl/mul_seq_32_pkg.sv
// ============================================================================
// mul_seq_32_pkg : shared op encodings, FSM state type and helpers for mul_seq_32
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_seq_32_pkg;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  localparam int CALC_CYCLES = 32;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CALC   = 3'd1,
    S_NEG_LO = 3'd2,
    S_NEG_HI = 3'd3,
    S_DONE   = 3'd4
  } mul_state_e;

  // Two's-complement magnitude without an adder: every bit above the lowest
  // set bit is inverted. 0x80000000 maps to itself, which is correct unsigned.
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    logic [31:0] r;
    logic        seen;
    r    = x;
    seen = 1'b0;
    if (is_signed && x[31]) begin
      for (int i = 0; i < 32; i++) begin
        r[i] = x[i] ^ seen;
        seen = seen | x[i];
      end
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mul_seq_32_add_c_32.sv
// ============================================================================
// add_c_32 : 32-bit adder with carry in/out, the only adder in the datapath
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module add_c_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {32'd0, cin};

endmodule

`default_nettype wire

// File: rtl/mul_seq_32.sv
// ============================================================================
// mul_seq_32 : sequential shift-add RV32M multiplier (MUL/MULH/MULHSU/MULHU)
// Optional macro MUL_SEQ_ZERO_BYPASS_EN: zero operand skips straight to DONE.
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_seq_32
  import mul_seq_32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [5:0] CNT_LAST = 6'(CALC_CYCLES - 1);

  mul_state_e       state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] result_q, result_d;

  logic [WIDTH-1:0] add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic             a_signed, b_signed;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign a_signed = (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  assign b_signed = (op == MUL_OP_MULH);
  assign mag_a    = mag32(a, a_signed);
  assign mag_b    = mag32(b, b_signed);

  add_c_32 u_add (
    .a   (add_a),
    .b   (add_b),
    .cin (add_cin),
    .sum (add_sum),
    .cout(add_cout)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    carry_d  = carry_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    result_d = result_q;
    add_a    = '0;
    add_b    = '0;
    add_cin  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          neg_d   = (a_signed & a[WIDTH-1]) ^ (b_signed & b[WIDTH-1]);
          mcand_d = mag_a;
          lo_d    = mag_b;
          hi_d    = '0;
          carry_d = 1'b0;
          cnt_d   = '0;
`ifdef MUL_SEQ_ZERO_BYPASS_EN
          state_d = (mag_a == '0 || mag_b == '0) ? S_DONE : S_CALC;
`else
          state_d = S_CALC;
`endif
        end
      end
      S_CALC: begin
        // Add (or add zero) then shift {carry, hi, lo} right by one
        add_a   = hi_q;
        add_b   = lo_q[0] ? mcand_q : '0;
        hi_d    = {add_cout, add_sum[WIDTH-1:1]};
        lo_d    = {add_sum[0], lo_q[WIDTH-1:1]};
        carry_d = 1'b0;
        cnt_d   = cnt_q + 6'd1;
        if (cnt_q == CNT_LAST) begin
          state_d = neg_q ? S_NEG_LO : S_DONE;
        end
      end
      S_NEG_LO: begin
        add_a   = ~lo_q;
        add_cin = 1'b1;
        lo_d    = add_sum;
        carry_d = add_cout;
        state_d = S_NEG_HI;
      end
      S_NEG_HI: begin
        add_a   = ~hi_q;
        add_cin = carry_q;
        hi_d    = add_sum;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
    end

    // Only the zero-bypass path enters DONE directly from IDLE
    if (state_d == S_DONE && state_q != S_DONE) begin
      if (state_q == S_IDLE) begin
        result_d = '0;
      end else begin
        result_d = (op_q == MUL_OP_MUL) ? lo_d : hi_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      carry_q  <= 1'b0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      carry_q  <= carry_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_mul_seq_32.sv
// ============================================================================
// tb_mul_seq_32 : directed self-checking bench for mul_seq_32
// Rev 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mul_seq_32;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op    = 2'b00;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  mul_seq_32 #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issues one op; lat counts negedges after the accepting edge until done.
  // A nonzero inj pulses a competing start at that count.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input int inj, output logic [31:0] r, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      start = (lat == inj);
      if (lat == inj) begin
        op = 2'b11; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    r = result;
  endtask

  task automatic count_dones(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
  endtask

  initial begin
    logic [31:0] r;
    int          lat;
    int          nd;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    rst_n = 1'b1;

    run_op(2'b00, 32'd7, 32'd6, 0, r, lat);
    check("mul_7x6", r, 32'h0000002A);
    check("mul_7x6_lat", lat, 33);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("idle_busy", busy, 0);

    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, r, lat);
    check("mulhu_ff", r, 32'hFFFFFFFE);
    check("mulhu_ff_lat", lat, 33);

    run_op(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, r, lat);
    check("mul_ff", r, 32'h00000001);
    check("mul_ff_lat", lat, 33);

    run_op(2'b01, 32'h80000000, 32'h80000000, 0, r, lat);
    check("mulh_min", r, 32'h40000000);
    check("mulh_min_lat", lat, 33);

    run_op(2'b10, 32'hFFFFFFFF, 32'd2, 0, r, lat);
    check("mulhsu_neg", r, 32'hFFFFFFFF);
    check("mulhsu_neg_lat", lat, 35);

    // Flush at clock 10 of a 5*5 multiply
    @(negedge clk);
    op = 2'b00; a = 32'd5; b = 32'd5; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", busy, 0);
    count_dones(40, nd);
    check("flush_nodone", nd, 0);
    check("flush_keep", result, 32'hFFFFFFFF);

    run_op(2'b00, 32'd5, 32'd5, 0, r, lat);
    check("after_flush", r, 32'd25);
    check("after_flush_lat", lat, 33);

    run_op(2'b00, 32'd3, 32'd4, 5, r, lat);
    check("busy_start", r, 32'd12);
    check("busy_start_lat", lat, 33);

    @(negedge clk);
    op = 2'b00; a = 32'd9; b = 32'd9; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("sf_busy", busy, 0);
    count_dones(40, nd);
    check("sf_nodone", nd, 0);
    check("sf_keep", result, 32'd12);

    run_op(2'b00, 32'd0, 32'd123, 0, r, lat);
    check("zero_res", r, 32'd0);
`ifdef MUL_SEQ_ZERO_BYPASS_EN
    check("zero_lat", lat, 1);
`else
    check("zero_lat", lat, 33);
`endif

    run_op(2'b00, 32'hFFFFFFFD, 32'd5, 0, r, lat);
    check("mul_m3x5", r, 32'hFFFFFFF1);
    check("mul_m3x5_lat", lat, 33);

    run_op(2'b01, 32'd5, 32'hFFFFFFFD, 0, r, lat);
    check("mulh_5xm3", r, 32'hFFFFFFFF);
    check("mulh_5xm3_lat", lat, 35);

    // Reset in the middle of CALC
    @(negedge clk);
    op = 2'b00; a = 32'd7; b = 32'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("calc_busy", busy, 1);
    rst_n = 1'b0; flush = 1'b1; start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1; flush = 1'b0; start = 1'b0;
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_result", result, 0);
    count_dones(40, nd);
    check("mid_rst_nodone", nd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
